// File: rtl/counter.sv
// counter: synchronous up/down modulo counter with clock enable, parallel
// load (clamped to MODULUS-1) and a combinational terminal-count flag.
// Count range is 0..MODULUS-1; the default build wraps at both ends.
// Optional build macro COUNTER_SATURATE_EN: the count holds at the limit in
// the current direction instead of wrapping.
module counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Reject configurations whose range cannot be represented in WIDTH bits.
  generate
    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
      $error("counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
  // One extra bit so that MODULUS == 2**WIDTH is representable; in that case
  // no load value can be out of range and the clamp never fires.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] load_clamped_s;
  logic             at_max_s;
  logic             at_min_s;
  logic             tc_s;

  // Decode the limits and clamp an out-of-range load value to the top of range.
  always_comb begin
    at_max_s = (count_q == MAX_VAL);
    at_min_s = (count_q == ZERO_VAL);
    if ({1'b0, load_value} >= MOD_EXT) begin
      load_clamped_s = MAX_VAL;
    end else begin
      load_clamped_s = load_value;
    end
  end

  // Next-count selection: load beats a step; reset is applied in the flop.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_clamped_s;
    end else if (enable) begin
      if (up_dn) begin
        if (at_max_s) begin
`ifdef COUNTER_SATURATE_EN
          count_d = MAX_VAL;
`else
          count_d = ZERO_VAL;
`endif
        end else begin
          count_d = count_q + ONE_VAL;
        end
      end else begin
        if (at_min_s) begin
`ifdef COUNTER_SATURATE_EN
          count_d = ZERO_VAL;
`else
          count_d = MAX_VAL;
`endif
        end else begin
          count_d = count_q - ONE_VAL;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset taking top priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= ZERO_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count: high in the cycle whose edge would wrap (or, when
  // saturating, while the count sits at the limit and is being pushed into it).
  always_comb begin
    tc_s = 1'b0;
    if (enable && reset && !load) begin
      if (up_dn) begin
        tc_s = at_max_s;
      end else begin
        tc_s = at_min_s;
      end
    end else begin
      tc_s = 1'b0;
    end
  end

  assign count = count_q;
  assign tc    = tc_s;

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed test of two counter instances, the default 4-bit
// modulo-16 build and a 5-bit modulo-10 build (non power-of-two wrap and
// load clamping). Works with or without COUNTER_SATURATE_EN.
module tb_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       up_dn;
  logic       load;
  logic [3:0] lv_a;
  logic [4:0] lv_b;
  logic [3:0] cnt_a;
  logic [4:0] cnt_b;
  logic       tc_a;
  logic       tc_b;

  int n_vec = 0;
  int n_err = 0;
  int m_a   = 0;
  int m_b   = 0;

  always #5 clk = ~clk;

  counter #(.WIDTH(4), .MODULUS(16)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_value(lv_a), .count(cnt_a), .tc(tc_a)
  );

  counter #(.WIDTH(5), .MODULUS(10)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_value(lv_b), .count(cnt_b), .tc(tc_b)
  );

  // Compare one observed value with its expected value and log a miscompare.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference next count for a counter of range 0..m-1.
  function automatic int model_next(int c, int m, int lv);
    if (!reset) return 0;
    if (load) return (lv >= m) ? m - 1 : lv;
    if (!enable) return c;
    if (up_dn) begin
      if (c == m - 1) return SAT ? m - 1 : 0;
      return c + 1;
    end
    if (c == 0) return SAT ? 0 : m - 1;
    return c - 1;
  endfunction

  // Reference terminal-count flag.
  function automatic bit model_tc(int c, int m);
    return enable && reset && !load && (up_dn ? (c == m - 1) : (c == 0));
  endfunction

  // One clock: check tc before the edge, then the new counts after it.
  task automatic tick(input string tag);
    #1;
    check({tag, "/tc_a"}, 32'(tc_a), 32'(model_tc(m_a, 16)));
    check({tag, "/tc_b"}, 32'(tc_b), 32'(model_tc(m_b, 10)));
    @(posedge clk);
    m_a = model_next(m_a, 16, int'(lv_a));
    m_b = model_next(m_b, 10, int'(lv_b));
    #1;
    check({tag, "/cnt_a"}, 32'(cnt_a), 32'(m_a));
    check({tag, "/cnt_b"}, 32'(cnt_b), 32'(m_b));
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    up_dn  = 1'b1;
    load   = 1'b0;
    lv_a   = 4'd0;
    lv_b   = 5'd0;

    // Reset with enable high, then hold in reset.
    tick("rst0");
    check("rst0_hand", 32'(cnt_a), 32'd0);
    tick("rst1");
    check("rst_hold_hand", 32'(cnt_a), 32'd0);

    // Up count for 16 edges.
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick("up");
      check("up_hand", 32'(cnt_a), SAT ? 32'((i > 15) ? 15 : i) : 32'(i % 16));
    end
    check("up_end_b", 32'(cnt_b), SAT ? 32'd9 : 32'd6);

    // Enable low: hold.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick("hold");
    check("hold_hand", 32'(cnt_a), SAT ? 32'd15 : 32'd0);

    // Return to 0, then count down.
    reset  = 1'b0;
    enable = 1'b1;
    tick("rst2");
    reset = 1'b1;
    up_dn = 1'b0;
    #1;
    check("dn_tc_at0", 32'(tc_a), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick("dn");
      check("dn_hand", 32'(cnt_a), SAT ? 32'd0 : 32'(16 - i));
    end
    check("dn_end_b", 32'(cnt_b), SAT ? 32'd0 : 32'd6);

    // Load wins over enable; no extra step.
    up_dn = 1'b1;
    load  = 1'b1;
    lv_a  = 4'd9;
    lv_b  = 5'd9;
    tick("ld9");
    check("ld9_hand", 32'(cnt_a), 32'd9);
    lv_a = 4'd13;
    lv_b = 5'd20;
    tick("ld_clamp");
    check("ld_clamp_hand", 32'(cnt_b), 32'd9);
    lv_b = 5'd31;
    tick("ld_clamp31");

    // Up wrap on the modulo-10 instance from 9.
    load = 1'b0;
    tick("wrap_b");
    check("wrap_b_hand", 32'(cnt_b), SAT ? 32'd9 : 32'd0);

    // Reset mid-count wins, then counting resumes from 0.
    load = 1'b1;
    lv_a = 4'd7;
    lv_b = 5'd7;
    tick("ld7");
    load  = 1'b0;
    reset = 1'b0;
    tick("rst_mid");
    check("rst_mid_hand", 32'(cnt_a), 32'd0);
    reset = 1'b1;
    tick("resume");
    check("resume_hand", 32'(cnt_a), 32'd1);

    // Down wrap on the modulo-10 instance from 0.
    reset = 1'b0;
    tick("rst3");
    reset = 1'b1;
    up_dn = 1'b0;
    tick("dn_b");
    check("dn_b_hand", 32'(cnt_b), SAT ? 32'd0 : 32'd9);

    // Saturate up on the 16 instance: load 15 then push up twice.
    up_dn = 1'b1;
    load  = 1'b1;
    lv_a  = 4'd15;
    tick("ld15");
    load = 1'b0;
    tick("top1");
    tick("top2");
    check("top_hand", 32'(cnt_a), SAT ? 32'd15 : 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
